// File: rtl/mmu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmu_arbiter_pkg
// Purpose  : Shared types and constants for the TLB access arbiter:
//            grant/serve state encoding, CP0 exception codes, and the
//            alignment helper used by the address checker.
// Revision : 1.0 - initial release
// ============================================================================
package mmu_arbiter_pkg;

  // Port served in the previous cycle (its ack is visible in this cycle).
  typedef enum logic [1:0] {
    SRV_IDLE = 2'd0,
    SRV_IF   = 2'd1,
    SRV_MEM  = 2'd2
  } srv_e;

  localparam logic [4:0] c_EXC_TLBL = 5'h02;
  localparam logic [4:0] c_EXC_TLBS = 5'h03;
  localparam logic [4:0] c_EXC_ADEL = 5'h04;
  localparam logic [4:0] c_EXC_ADES = 5'h05;

  localparam logic [1:0] c_SIZE_BYTE = 2'd0;
  localparam logic [1:0] c_SIZE_HALF = 2'd1;

  // Fetches are always word accesses; data size 3 is treated as a word.
  function automatic logic misaligned(input logic       is_mem,
                                      input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    if (!is_mem) begin
      r = (addr_lo != 2'b00);
    end else if (size == c_SIZE_BYTE) begin
      r = 1'b0;
    end else if (size == c_SIZE_HALF) begin
      r = addr_lo[0];
    end else begin
      r = (addr_lo != 2'b00);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mmu_arbiter_if
// Purpose  : Bundles the fetch/memory translation handshakes and the TLB
//            lookup port of the arbiter.
//   slave  : arbiter view (requests and TLB result in, acks/results and
//            TLB vaddr out)
//   master : environment view (pipeline stages plus tlb_reg)
// Revision : 1.0 - initial release
// ============================================================================
interface mmu_arbiter_if;
  logic        user_mode_i;
  logic        if_req_i;
  logic [31:0] if_vaddr_i;
  logic        if_ack_o;
  logic [31:0] if_paddr_o;
  logic        if_exc_o;
  logic        mem_req_i;
  logic [31:0] mem_vaddr_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic        mem_ack_o;
  logic [31:0] mem_paddr_o;
  logic        mem_exc_o;
  logic [4:0]  exccode_o;
  logic [31:0] badvaddr_o;
  logic [31:0] tlb_vaddr_o;
  logic        tlb_hit_i;
  logic [31:0] tlb_paddr_i;

  modport slave (
    input  user_mode_i, if_req_i, if_vaddr_i, mem_req_i, mem_vaddr_i,
           mem_we_i, mem_size_i, tlb_hit_i, tlb_paddr_i,
    output if_ack_o, if_paddr_o, if_exc_o, mem_ack_o, mem_paddr_o,
           mem_exc_o, exccode_o, badvaddr_o, tlb_vaddr_o
  );

  modport master (
    output user_mode_i, if_req_i, if_vaddr_i, mem_req_i, mem_vaddr_i,
           mem_we_i, mem_size_i, tlb_hit_i, tlb_paddr_i,
    input  if_ack_o, if_paddr_o, if_exc_o, mem_ack_o, mem_paddr_o,
           mem_exc_o, exccode_o, badvaddr_o, tlb_vaddr_o
  );
endinterface
`default_nettype wire

// File: rtl/mmu_arbiter_addr_check.sv
`default_nettype none
// ============================================================================
// Module   : mmu_addr_check
// Purpose  : Combinational alignment / privilege / segment checker for the
//            granted address.
//   i_is_mem      : 1 = data access, 0 = fetch
//   i_we          : store (ignored for fetch)
//   i_size        : data access size
//   i_vaddr_hi    : vaddr[31:30]
//   i_vaddr_lo    : vaddr[1:0]
//   i_user_mode   : user mode
//   i_tlb_hit     : TLB lookup hit for this address
//   o_exc         : exception raised
//   o_exccode     : exception code (0 when no exception)
//   o_unmapped    : address is in kseg0/kseg1 (TLB bypassed)
// Revision : 1.0 - initial release
// ============================================================================
module mmu_addr_check
  import mmu_arbiter_pkg::*;
(
  input  wire logic       i_is_mem,
  input  wire logic       i_we,
  input  wire logic [1:0] i_size,
  input  wire logic [1:0] i_vaddr_hi,
  input  wire logic [1:0] i_vaddr_lo,
  input  wire logic       i_user_mode,
  input  wire logic       i_tlb_hit,
  output logic            o_exc,
  output logic [4:0]      o_exccode,
  output logic            o_unmapped
);

  logic w_store;
  logic w_addr_err;

  assign w_store    = i_is_mem & i_we;
  // Alignment and privilege share the same exception codes, so they merge.
  assign w_addr_err = misaligned(i_is_mem, i_size, i_vaddr_lo) |
                      (i_user_mode & i_vaddr_hi[1]);
  assign o_unmapped = (i_vaddr_hi == 2'b10);

  always_comb begin
    o_exc     = 1'b0;
    o_exccode = 5'd0;
    if (w_addr_err) begin
      o_exc     = 1'b1;
      o_exccode = w_store ? c_EXC_ADES : c_EXC_ADEL;
    end else if (!o_unmapped && !i_tlb_hit) begin
      o_exc     = 1'b1;
      o_exccode = w_store ? c_EXC_TLBS : c_EXC_TLBL;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mmu_arbiter
// Purpose  : Single-port TLB arbiter and translation stage. Grants the TLB
//            lookup to MEM or IF each cycle, checks the granted address and
//            returns a one-cycle ack with paddr or exception info.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mmu_arbiter_if.slave (requests, acks, results, TLB port)
// Revision : 1.0 - initial release
// ============================================================================
module mmu_arbiter
  import mmu_arbiter_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     rst,
  mmu_arbiter_if.slave  bus
);

  srv_e        r_srv;
  logic [31:0] r_paddr;
  logic        r_exc;
  logic [4:0]  r_exccode;
  logic [31:0] r_badvaddr;

  srv_e        w_grant;
  logic        w_if_acked;
  logic        w_mem_acked;
  logic        w_if_elig;
  logic        w_mem_elig;
  logic        w_is_mem;
  logic [31:0] w_vaddr;
  logic        w_exc;
  logic [4:0]  w_exccode;
  logic        w_unmapped;
  logic [31:0] w_paddr;
  logic        w_if_ack;
  logic        w_mem_ack;

  assign w_if_acked  = (r_srv == SRV_IF);
  assign w_mem_acked = (r_srv == SRV_MEM);

  // A port acked this cycle is not re-served; this also gives IF a turn at
  // least every second cycle while MEM is busy.
  assign w_if_elig  = bus.if_req_i  & ~w_if_acked;
  assign w_mem_elig = bus.mem_req_i & ~w_mem_acked;

  always_comb begin
    w_grant = SRV_IDLE;
    if (w_mem_elig) begin
      w_grant = SRV_MEM;
    end else if (w_if_elig) begin
      w_grant = SRV_IF;
    end
  end

  assign w_is_mem        = (w_grant == SRV_MEM);
  assign w_vaddr         = w_is_mem ? bus.mem_vaddr_i : bus.if_vaddr_i;
  assign bus.tlb_vaddr_o = w_vaddr;

  mmu_addr_check u_check (
    .i_is_mem    (w_is_mem),
    .i_we        (bus.mem_we_i),
    .i_size      (bus.mem_size_i),
    .i_vaddr_hi  (w_vaddr[31:30]),
    .i_vaddr_lo  (w_vaddr[1:0]),
    .i_user_mode (bus.user_mode_i),
    .i_tlb_hit   (bus.tlb_hit_i),
    .o_exc       (w_exc),
    .o_exccode   (w_exccode),
    .o_unmapped  (w_unmapped)
  );

  assign w_paddr = w_exc      ? 32'd0 :
                   w_unmapped ? {3'b000, w_vaddr[28:0]} :
                                bus.tlb_paddr_i;

  // Result registers stay zero in cycles without a grant, so the shared
  // exccode/badvaddr outputs read 0 whenever nothing is acked.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_srv      <= SRV_IDLE;
      r_paddr    <= 32'd0;
      r_exc      <= 1'b0;
      r_exccode  <= 5'd0;
      r_badvaddr <= 32'd0;
    end else begin
      r_srv <= w_grant;
      if (w_grant != SRV_IDLE) begin
        r_paddr    <= w_paddr;
        r_exc      <= w_exc;
        r_exccode  <= w_exccode;
        r_badvaddr <= w_exc ? w_vaddr : 32'd0;
      end else begin
        r_paddr    <= 32'd0;
        r_exc      <= 1'b0;
        r_exccode  <= 5'd0;
        r_badvaddr <= 32'd0;
      end
    end
  end

  // Outputs are masked while rst is high so that an ack already registered
  // before reset arrived is discarded in the reset cycle itself.
  assign w_if_ack  = w_if_acked  & ~rst;
  assign w_mem_ack = w_mem_acked & ~rst;

  assign bus.if_ack_o    = w_if_ack;
  assign bus.if_paddr_o  = w_if_ack ? r_paddr : 32'd0;
  assign bus.if_exc_o    = w_if_ack & r_exc;
  assign bus.mem_ack_o   = w_mem_ack;
  assign bus.mem_paddr_o = w_mem_ack ? r_paddr : 32'd0;
  assign bus.mem_exc_o   = w_mem_ack & r_exc;
  assign bus.exccode_o   = rst ? 5'd0  : r_exccode;
  assign bus.badvaddr_o  = rst ? 32'd0 : r_badvaddr;

endmodule
`default_nettype wire
